rcvr_arbiter: RTL

- Drains 2**CHW serial frame receivers (header-match / 8-bit body receivers with ready/overrun/reading handshake) into one downstream byte stream.
- Arbitrates round-robin between ready channels and issues the single-cycle `reading` acknowledge back to the winning receiver.
- Presents the byte with its channel number on a valid/ready output.
- Keeps per-channel sticky overrun flags for software.

---
 rtl/rcvr_arbiter.sv | 92 +++++++++
 1 files changed

// File: rtl/rcvr_arbiter.sv
// Round-robin drain of NCH serial frame receivers into one valid/ready byte stream,
// with a one-cycle reading acknowledge per grant and sticky per-channel overrun flags.
module rcvr_arbiter #(
    parameter int CHW = 2,
    parameter int DW  = 8,
    localparam int NCH = 2**CHW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NCH-1:0]    rx_ready,
    input  logic [NCH-1:0]    rx_overrun,
    input  logic [NCH*DW-1:0] rx_data,
    input  logic [NCH-1:0]    chan_en,
    output logic [NCH-1:0]    rx_reading,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic [CHW-1:0]    out_chan,
    output logic [NCH-1:0]    ovr_flag,
    input  logic [NCH-1:0]    ovr_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CHW-1:0]   last;
    logic [CHW-1:0]   winner;
    logic [CHW-1:0]   cand;
    logic             found;
    logic             grant;
    logic [NCH-1:0]   eligible;
    logic [NCH-1:0]   winner_onehot;

    // Search starts just after the previous winner; the final offset wraps back to last itself.
    always_comb begin
        eligible = rx_ready & chan_en;
        found    = 1'b0;
        winner   = last;
        cand     = last;
        for (int unsigned k = 1; k <= NCH; k++) begin
            cand = last + k[CHW-1:0];
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        winner_onehot         = '0;
        winner_onehot[winner] = 1'b1;
    end

    always_comb begin
        state_next = IDLE;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant      = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD:    state_next = out_ready ? IDLE : HOLD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last       <= '1;
            rx_reading <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_chan   <= '0;
            ovr_flag   <= '0;
        end else begin
            state      <= state_next;
            out_valid  <= (state_next == HOLD);
            rx_reading <= grant ? winner_onehot : '0;
            ovr_flag   <= (ovr_flag & ~ovr_clr) | rx_overrun;
            if (grant) begin
                out_data <= rx_data[int'(winner)*DW +: DW];
                out_chan <= winner;
                last     <= winner;
            end
        end
    end

endmodule
